// File: rtl/logic_48_pkg.sv
// Shared constants for the logic_48 bitwise unit: function encodings and default width.
package logic_48_pkg;

  localparam int unsigned LOGIC_48_WIDTH = 48;

  // Function-select encodings for LOGIC_OP
  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_XNOR = 3;
  localparam int unsigned OP_NAND = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_ANDN = 6;  // A AND NOT B
  localparam int unsigned OP_ORN  = 7;  // A OR NOT B
  localparam int unsigned OP_MAX  = 7;

endpackage

// File: rtl/logic_48_func.sv
// Purely combinational WIDTH-bit bitwise function, selected at elaboration by LOGIC_OP.
module logic_48_func
  import logic_48_pkg::*;
#(
  parameter int unsigned WIDTH    = LOGIC_48_WIDTH,
  parameter int unsigned LOGIC_OP = OP_XOR
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Bitwise function; LOGIC_OP is constant so only one arm survives synthesis
  always_comb begin
    y = '0;
    case (LOGIC_OP)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_48.sv
// Two-stage registered 48-bit bitwise logic unit (DSP48E logic-mode style):
// registered A/B, combinational function, registered result.
module logic_48
  import logic_48_pkg::*;
#(
  parameter int unsigned WIDTH    = LOGIC_48_WIDTH,
  parameter int unsigned LOGIC_OP = OP_XOR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] AIN,
  input  logic [WIDTH-1:0] BIN,
  output logic [WIDTH-1:0] LOGIC_OUT
);

  // Reject illegal configurations at elaboration
  if (WIDTH < 1 || WIDTH > LOGIC_48_WIDTH) begin : g_bad_width
    $fatal(1, "logic_48: WIDTH must be in 1..48");
  end
  if (LOGIC_OP > OP_MAX) begin : g_bad_op
    $fatal(1, "logic_48: LOGIC_OP must be in 0..7");
  end

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] f_res;

  // Stage 1: capture operands every cycle; reset flushes in-flight data
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= AIN;
      b_q <= BIN;
    end
  end

  logic_48_func #(
    .WIDTH    (WIDTH),
    .LOGIC_OP (LOGIC_OP)
  ) u_func (
    .a (a_q),
    .b (b_q),
    .y (f_res)
  );

  // Stage 2: register result; reset forces 0 even for inverting functions
  always_ff @(posedge CLK) begin
    if (RST) begin
      LOGIC_OUT <= '0;
    end else begin
      LOGIC_OUT <= f_res;
    end
  end

endmodule

// File: tb/tb_logic_48.sv
// Self-checking bench for logic_48: four builds (XOR, AND, OR, XNOR) share one stimulus stream;
// a scoreboard queue holds the expected output for each upcoming clock edge.
module tb_logic_48;
  import logic_48_pkg::*;

  localparam int unsigned W = 48;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] a;
    logic [W-1:0] o;
    logic [W-1:0] n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ain = '0;
  logic [W-1:0] bin = '0;
  logic [W-1:0] out_xor, out_and, out_or, out_xnor;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  logic_48 u_xor (
    .CLK(clk), .RST(rst), .AIN(ain), .BIN(bin), .LOGIC_OUT(out_xor)
  );
  logic_48 #(.LOGIC_OP(OP_AND)) u_and (
    .CLK(clk), .RST(rst), .AIN(ain), .BIN(bin), .LOGIC_OUT(out_and)
  );
  logic_48 #(.LOGIC_OP(OP_OR)) u_or (
    .CLK(clk), .RST(rst), .AIN(ain), .BIN(bin), .LOGIC_OUT(out_or)
  );
  logic_48 #(.LOGIC_OP(OP_XNOR)) u_xnor (
    .CLK(clk), .RST(rst), .AIN(ain), .BIN(bin), .LOGIC_OUT(out_xnor)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.x = a ^ b;
    e.a = a & b;
    e.o = a | b;
    e.n = ~(a ^ b);
    return e;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance one edge, then compare all builds against the scoreboard
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    exp_t e;
    ain = a;
    bin = b;
    rst = r;
    if (r) begin
      exp_q.delete();
      exp_q.push_back('0);            // this edge: all outputs cleared
      exp_q.push_back(model('0, '0)); // next edge: f(0,0) from flushed stage 1
    end else begin
      exp_q.push_back(model(a, b));   // appears two edges from now
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_xor", out_xor, e.x);
      check("sb_and", out_and, e.a);
      check("sb_or", out_or, e.o);
      check("sb_xnor", out_xnor, e.n);
    end
  endtask

  logic [W-1:0] va[4] = '{48'd3, 48'd2020, 48'd10, 48'd1115};
  logic [W-1:0] vb[4] = '{48'd514, 48'd2000, 48'd14, 48'd1111};
  logic [W-1:0] vx[4] = '{48'h201, 48'h034, 48'h004, 48'h00C};
  logic [W-1:0] vand[4] = '{48'h002, 48'h7C0, 48'h00A, 48'h453};
  logic [W-1:0] vor[4] = '{48'h203, 48'h7F4, 48'h00E, 48'h45F};

  initial begin
    // Reset held for two edges with live operands
    step(48'd3, 48'd514, 1'b1);
    check("rst_xor_e1", out_xor, '0);
    check("rst_xnor_e1", out_xnor, '0);
    step(48'd3, 48'd514, 1'b1);
    check("rst_xor_e2", out_xor, '0);
    check("rst_xnor_e2", out_xnor, '0);

    // Release: first edge computes f(0,0)
    step(48'd3, 48'd514, 1'b0);
    check("rel_xor_e1", out_xor, '0);
    check("rel_xnor_e1", out_xnor, 48'hFFFF_FFFF_FFFF);
    step(48'd3, 48'd514, 1'b0);
    step(48'd3, 48'd514, 1'b0);
    check("rel_xor_e3", out_xor, 48'h0000_0000_0201);
    check("rel_xnor_e3", out_xnor, 48'hFFFF_FFFF_FDFE);

    // Directed vectors, each held two cycles
    for (int i = 0; i < 4; i++) begin
      step(va[i], vb[i], 1'b0);
      step(va[i], vb[i], 1'b0);
      check($sformatf("vec%0d_xor", i), out_xor, vx[i]);
      check($sformatf("vec%0d_and", i), out_and, vand[i]);
      check($sformatf("vec%0d_or", i), out_or, vor[i]);
    end

    // Full-width operands
    step(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 1'b0);
    step(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 1'b0);
    check("full_xor", out_xor, 48'h5555_5555_5555);
    check("full_and", out_and, 48'hAAAA_AAAA_AAAA);

    // Back-to-back random operands with a one-cycle reset mid-stream
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i == 20) begin
        step(ra, rb, 1'b1);
        check("mid_rst_xor", out_xor, '0);
        check("mid_rst_xnor", out_xnor, '0);
      end else if (i == 21) begin
        step(ra, rb, 1'b0);
        check("mid_flush_xor", out_xor, '0);
        check("mid_flush_xnor", out_xnor, 48'hFFFF_FFFF_FFFF);
      end else begin
        step(ra, rb, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_48.md
Name: logic_48

Overview:
- Two-operand, 48-bit bitwise logic unit.
- Models the logic mode of a DSP48E slice: registered A/B inputs, a combinational bitwise function, and a registered P output.
- Used as a datapath primitive wherever wide bitwise combination of two buses is needed.
- The function is fixed at elaboration time by a parameter; there is no run-time opcode port.

Parameters:
- WIDTH, 48, operand and result width in bits; legal range 1..48.
- LOGIC_OP, 2 (XOR), function select:
  - 0 = AND
  - 1 = OR
  - 2 = XOR
  - 3 = XNOR
  - 4 = NAND
  - 5 = NOR
  - 6 = A AND NOT B
  - 7 = A OR NOT B
  - any other value is an elaboration-time error.

Ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- AIN  input  WIDTH  operand A; unsigned bit vector.
- BIN  input  WIDTH  operand B; unsigned bit vector.
- LOGIC_OUT  output  WIDTH  registered result of LOGIC_OP applied to A and B.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port CLK, reset port RST.
- Pipeline, two register stages:
  - Stage 1: a_q <= AIN and b_q <= BIN on every rising edge.
  - Stage 2: LOGIC_OUT <= f(a_q, b_q) on every rising edge.
- Latency: exactly 2 rising edges from AIN/BIN sampled to LOGIC_OUT updated.
- Throughput: one result per cycle. No enables and no handshake; the pipeline always advances.
- Reset: while RST=1 at a rising edge, a_q, b_q and LOGIC_OUT all load 0.
  - LOGIC_OUT reads 0 from the first reset edge onward, for every LOGIC_OP, including the inverting ones.
- Reset release:
  - On the first edge with RST=0, stage 2 computes f(0,0), e.g. all-ones for XNOR/NAND/NOR/A OR NOT B. This is expected behaviour.
  - Valid operand results appear from the second edge after release.
- Reset mid-stream: flushes both stages. Data in flight is discarded, not held.
- Arithmetic: purely bitwise, bit i of the result depends only on bit i of A and B. No carry, no sign handling, no saturation.
- Unknown inputs: X/Z on AIN/BIN propagate per standard bitwise semantics. Reset clears them.
- No combinational path from inputs to LOGIC_OUT.

Decomposition:
- Shared package logic_48_pkg holds:
  - LOGIC_OP encoding constants: OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_ANDN, OP_ORN.
  - Default width constant LOGIC_48_WIDTH = 48.
- One natural sub-module: logic_48_func, a purely combinational WIDTH-bit bitwise function selected by LOGIC_OP.
  - The top instantiates it between the input and output registers.
  - The parameter range check lives in the top.

Test Plan:
- Reset: hold RST=1 for 2 edges with AIN=3, BIN=514 -> LOGIC_OUT=0 throughout.
  - After release, the third edge with RST=0 gives 0x000000000201 (XOR).
- XOR sequence (default), each value held ≥2 cycles, result checked 2 edges after apply:
  - 3 ^ 514 -> 0x201
  - 2020 ^ 2000 -> 0x034
  - 10 ^ 14 -> 0x004
  - 1115 ^ 1111 -> 0x00C
- AND build (LOGIC_OP=0), same vectors -> 0x002, 0x7C0, 0x00A, 0x453.
- OR build (LOGIC_OP=1), same vectors -> 0x203, 0x7F4, 0x00E, 0x45F.
- Full-width and latency:
  - AIN=0xFFFFFFFFFFFF, BIN=0xAAAAAAAAAAAA -> XOR 0x555555555555.
  - Then change operands every cycle with random values -> each output equals the model of the inputs applied exactly 2 edges earlier.
  - Assert RST for one cycle mid-stream -> output 0 at that edge, pipeline flushed.
- XNOR build (LOGIC_OP=3):
  - Reset -> LOGIC_OUT=0.
  - First edge after release -> 0xFFFFFFFFFFFF.
  - 3 vs 514 -> 0xFFFFFFFFFDFE.
